// File: rtl/gc_axil_master_if.sv
// AXI4-Lite register-port bundle for the Garnet global controller (AW/W/B/AR/R).
// Latency: none, wires only.
// Backpressure: plain AXI valid/ready on every channel.
// Ports: master drives addresses, write data, valids and B/R readies; slave drives
//        the A/W readies, B/R valids, responses and read data.
interface gc_axil_master_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gc_axil_master.sv
// Single-outstanding AXI4-Lite initiator turning cmd beats into GC register accesses.
// Latency: 3 cycles command-to-response minimum, +1 per stalled handshake cycle.
// Backpressure: cmd_ready only in IDLE; rsp held stable until rsp_ready; TIMEOUT aborts a stuck slave.
// Ports: clk/reset; cmd_* command stream in; rsp_* response stream out;
//        gc (master modport) carries the GC AW/W/B/AR/R channels, all outputs registered.
module gc_axil_master #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  gc_axil_master_if.master        gc
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] tmo_cnt;
  logic                 aw_done;
  logic                 w_done;

  logic aw_hs;
  logic w_hs;
  logic busy;
  logic abort;

  assign aw_hs = gc.awvalid & gc.awready;
  assign w_hs  = gc.wvalid & gc.wready;
  assign busy  = (state == WR_REQ) || (state == WR_RESP) ||
                 (state == RD_REQ) || (state == RD_RESP);

  // A response arriving on the final counted cycle still wins over the abort;
  // a request phase still pending at that point does not.
  assign abort = (tmo_cnt == CNT_LAST) &&
                 ((state == WR_REQ) || (state == RD_REQ) ||
                  ((state == WR_RESP) && !gc.bvalid) ||
                  ((state == RD_RESP) && !gc.rvalid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
      gc.awaddr   <= '0;
      gc.awvalid  <= 1'b0;
      gc.wdata    <= '0;
      gc.wstrb    <= '0;
      gc.wvalid   <= 1'b0;
      gc.bready   <= 1'b0;
      gc.araddr   <= '0;
      gc.arvalid  <= 1'b0;
      gc.rready   <= 1'b0;
    end else if (abort) begin
      // Stuck slave: drop every GC valid/ready and report a SLVERR-style timeout.
      state       <= RSP;
      gc.awaddr   <= '0;
      gc.awvalid  <= 1'b0;
      gc.wdata    <= '0;
      gc.wstrb    <= '0;
      gc.wvalid   <= 1'b0;
      gc.bready   <= 1'b0;
      gc.araddr   <= '0;
      gc.arvalid  <= 1'b0;
      gc.rready   <= 1'b0;
      rsp_valid   <= 1'b1;
      rsp_timeout <= 1'b1;
      rsp_resp    <= 2'b10;
      rsp_rdata   <= '0;
    end else begin
      if (busy) begin
        tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready   <= 1'b0;
            tmo_cnt     <= '0;
            rsp_write   <= cmd_write;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            if (cmd_write) begin
              state      <= WR_REQ;
              gc.awaddr  <= cmd_addr;
              gc.awvalid <= 1'b1;
              gc.wdata   <= cmd_wdata;
              gc.wstrb   <= cmd_wstrb;
              gc.wvalid  <= 1'b1;
            end else begin
              state      <= RD_REQ;
              gc.araddr  <= cmd_addr;
              gc.arvalid <= 1'b1;
            end
          end
        end

        WR_REQ: begin
          // AW and W complete independently; the done flags remember the earlier one.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state      <= WR_RESP;
            gc.awaddr  <= '0;
            gc.awvalid <= 1'b0;
            gc.wdata   <= '0;
            gc.wstrb   <= '0;
            gc.wvalid  <= 1'b0;
            gc.bready  <= 1'b1;
          end else begin
            if (aw_hs) begin
              aw_done    <= 1'b1;
              gc.awaddr  <= '0;
              gc.awvalid <= 1'b0;
            end
            if (w_hs) begin
              w_done    <= 1'b1;
              gc.wdata  <= '0;
              gc.wstrb  <= STRB_WIDTH'(0);
              gc.wvalid <= 1'b0;
            end
          end
        end

        WR_RESP: begin
          if (gc.bvalid) begin
            state     <= RSP;
            gc.bready <= 1'b0;
            rsp_resp  <= gc.bresp;
            rsp_valid <= 1'b1;
          end
        end

        RD_REQ: begin
          if (gc.arready) begin
            state      <= RD_RESP;
            gc.araddr  <= '0;
            gc.arvalid <= 1'b0;
            gc.rready  <= 1'b1;
          end
        end

        RD_RESP: begin
          if (gc.rvalid) begin
            state     <= RSP;
            gc.rready <= 1'b0;
            rsp_rdata <= gc.rdata;
            rsp_resp  <= gc.rresp;
            rsp_valid <= 1'b1;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
